// File: rtl/seq_1x01_tx_if.sv
// Handshake and serial-line bundle for seq_1x01_tx.
// The master side loads words; the slave side is the transmitter.
interface seq_1x01_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             last_bit;
  logic             tag_1101;
  logic             tag_1001;
  logic             busy;

  modport master (
    output data_in, load,
    input  ready, dout, dout_valid, last_bit, tag_1101, tag_1001, busy
  );

  modport slave (
    input  data_in, load,
    output ready, dout, dout_valid, last_bit, tag_1101, tag_1001, busy
  );
endinterface

// File: rtl/seq_1x01_tx.sv
// Serial pattern transmitter: parallel words in over load/ready, MSB-first bits out on dout.
// Optional even-parity bit after each word when SEQ_TX_PARITY_EN is defined.
module seq_1x01_tx #(
  parameter int   WIDTH    = 4,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = 1'b0
) (
  input logic           clk,
  input logic           reset,
  seq_1x01_tx_if.slave  bus
);

`ifdef SEQ_TX_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif
  localparam int CW = $clog2(LEN);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(LEN - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [GW-1:0]    gcnt_q;
  logic             dout_q, valid_q, last_q, t1101_q, t1001_q, ready_q, busy_q;
  logic             p1101_q, p1001_q;
  logic             next_bit_d;
  logic             accept;

`ifdef SEQ_TX_PARITY_EN
  localparam logic [CW-1:0] CNT_PAR = CW'(WIDTH - 1);
  logic par_q;

  always_comb begin
    next_bit_d = sr_q[WIDTH-1];
    if (cnt_q == CNT_PAR) next_bit_d = par_q;
  end
`else
  always_comb begin
    next_bit_d = sr_q[WIDTH-1];
  end
`endif

  assign accept = bus.load & ready_q;

  // sr_q holds the bits not yet on the line; dout_q is the bit currently driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      dout_q  <= IDLE_BIT;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      t1101_q <= 1'b0;
      t1001_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      p1101_q <= 1'b0;
      p1001_q <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= S_SHIFT;
      sr_q    <= bus.data_in << 1;
      cnt_q   <= '0;
      dout_q  <= bus.data_in[WIDTH-1];
      valid_q <= 1'b1;
      last_q  <= 1'b0;
      t1101_q <= 1'b0;
      t1001_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      p1101_q <= (bus.data_in[3:0] == 4'b1101);
      p1001_q <= (bus.data_in[3:0] == 4'b1001);
`ifdef SEQ_TX_PARITY_EN
      par_q   <= ^bus.data_in;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        S_SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q  <= cnt_q + CW'(1);
            sr_q   <= sr_q << 1;
            dout_q <= next_bit_d;
            if (cnt_q == CNT_PRE) begin
              last_q  <= 1'b1;
              t1101_q <= p1101_q;
              t1001_q <= p1001_q;
              ready_q <= (GAP == 0);
            end
          end else begin
            last_q  <= 1'b0;
            t1101_q <= 1'b0;
            t1001_q <= 1'b0;
            dout_q  <= IDLE_BIT;
            valid_q <= 1'b0;
            if (GAP == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_GAP;
              gcnt_q  <= '0;
              ready_q <= (GAP == 1);
            end
          end
        end
        S_GAP: begin
          if (gcnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            gcnt_q  <= gcnt_q + GW'(1);
            ready_q <= ((gcnt_q + GW'(1)) == GAP_LAST);
          end
        end
        default: begin
          state_q <= S_IDLE;
          dout_q  <= IDLE_BIT;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.last_bit   = last_q;
  assign bus.tag_1101   = t1101_q;
  assign bus.tag_1001   = t1001_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_seq_1x01_tx.sv
// Bench for seq_1x01_tx: GAP=0 and GAP=2 instances scored per cycle against a
// queue of expected line cycles built from each accepted word.
module tb_seq_1x01_tx;
  localparam int   W  = 4;
  localparam logic IB = 1'b0;
`ifdef SEQ_TX_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_1x01_tx_if #(.WIDTH(W)) bus0 ();
  seq_1x01_tx_if #(.WIDTH(W)) bus2 ();

  seq_1x01_tx #(.WIDTH(W), .GAP(0), .IDLE_BIT(IB)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  seq_1x01_tx #(.WIDTH(W), .GAP(2), .IDLE_BIT(IB)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct packed {
    logic dout;
    logic valid;
    logic last;
    logic t1101;
    logic t1001;
    logic rdy;
  } rec_t;

  rec_t        q0[$];
  rec_t        q2[$];
  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %b expected %b (dout,valid,last,t1101,t1001,ready,busy)",
                  tag, $time, got, exp);
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.dout = IB;
    r.rdy  = 1'b1;
    return r;
  endfunction

  function automatic rec_t cur(input int idx);
    if (idx == 0) return (q0.size() != 0) ? q0[0] : idle_rec();
    return (q2.size() != 0) ? q2[0] : idle_rec();
  endfunction

  function automatic logic [6:0] exp_outs(input rec_t r, input logic busy);
    return {r.dout, r.valid, r.last, r.t1101, r.t1001, r.rdy, busy};
  endfunction

  // Expected line cycles of one word: L bits then `gap` idle cycles.
  task automatic push_word(input int idx, input logic [W-1:0] w, input int gap);
    logic [L-1:0] bits;
    rec_t         r;
`ifdef SEQ_TX_PARITY_EN
    bits = {w, ^w};
`else
    bits = w;
`endif
    for (int i = 0; i < L; i++) begin
      r       = '0;
      r.dout  = bits[L-1-i];
      r.valid = 1'b1;
      r.last  = (i == L - 1);
      r.t1101 = r.last && (w[3:0] == 4'b1101);
      r.t1001 = r.last && (w[3:0] == 4'b1001);
      r.rdy   = r.last && (gap == 0);
      if (idx == 0) q0.push_back(r); else q2.push_back(r);
    end
    for (int j = 0; j < gap; j++) begin
      r      = '0;
      r.dout = IB;
      r.rdy  = (j == gap - 1);
      if (idx == 0) q0.push_back(r); else q2.push_back(r);
    end
  endtask

  task automatic step(input logic ld0, input logic [W-1:0] d0, input logic ld2, input logic [W-1:0] d2);
    logic acc0, acc2;
    @(negedge clk);
    check_eq("outs_g0", {bus0.dout, bus0.dout_valid, bus0.last_bit, bus0.tag_1101, bus0.tag_1001,
                         bus0.ready, bus0.busy}, exp_outs(cur(0), q0.size() != 0));
    check_eq("outs_g2", {bus2.dout, bus2.dout_valid, bus2.last_bit, bus2.tag_1101, bus2.tag_1001,
                         bus2.ready, bus2.busy}, exp_outs(cur(2), q2.size() != 0));
    bus0.load = ld0; bus0.data_in = d0;
    bus2.load = ld2; bus2.data_in = d2;
    acc0 = ld0 && cur(0).rdy;
    acc2 = ld2 && cur(2).rdy;
    @(posedge clk);
    if (q0.size() != 0) void'(q0.pop_front());
    if (q2.size() != 0) void'(q2.pop_front());
    if (acc0) push_word(0, d0, 0);
    if (acc2) push_word(2, d2, 2);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b0, 4'b0000);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         ld;
    reset = 1'b1;
    bus0.load = 1'b0; bus0.data_in = '0;
    bus2.load = 1'b0; bus2.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_g0", {bus0.dout, bus0.dout_valid, bus0.last_bit, bus0.tag_1101, bus0.tag_1001,
                        bus0.ready, bus0.busy}, exp_outs(idle_rec(), 1'b0));
    check_eq("rst_g2", {bus2.dout, bus2.dout_valid, bus2.last_bit, bus2.tag_1101, bus2.tag_1001,
                        bus2.ready, bus2.busy}, exp_outs(idle_rec(), 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // single word, then back-to-back 1001/1101 with load held
    step(1'b1, 4'b1101, 1'b1, 4'b1101);
    idle_steps(8);
    step(1'b1, 4'b1001, 1'b1, 4'b1001);
    for (int i = 0; i < 7; i++) step(1'b1, 4'b1101, 1'b1, 4'b1101);
    idle_steps(8);

    // 1010 then 0001 timed for the second gap cycle; mid-word loads are ignored
    step(1'b1, 4'b1010, 1'b1, 4'b1010);
    step(1'b1, 4'b0110, 1'b1, 4'b0110);
    idle_steps(4);
    step(1'b1, 4'b0001, 1'b1, 4'b0001);
    idle_steps(8);

    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       d = 4'b1101;
        1:       d = 4'b1001;
        default: d = W'($urandom);
      endcase
      step(ld, d, ld, d);
    end
    idle_steps(8);

    // asynchronous reset during the second bit of 1101
    step(1'b1, 4'b1101, 1'b1, 4'b1101);
    step(1'b0, 4'b0000, 1'b0, 4'b0000);
    #3 reset = 1'b1;
    #1;
    check_eq("midrst_g0", {bus0.dout, bus0.dout_valid, bus0.last_bit, bus0.tag_1101, bus0.tag_1001,
                           bus0.ready, bus0.busy}, exp_outs(idle_rec(), 1'b0));
    check_eq("midrst_g2", {bus2.dout, bus2.dout_valid, bus2.last_bit, bus2.tag_1101, bus2.tag_1001,
                           bus2.ready, bus2.busy}, exp_outs(idle_rec(), 1'b0));
    q0.delete();
    q2.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 4'b1001, 1'b1, 4'b1001);
    idle_steps(8);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/seq_1x01_tx.md
Name: seq_1x01_tx

Overview:
- Serial pattern transmitter. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single serial line.
- This line is the driver end of the serial `din` interface consumed by the team's 1x01 Moore sequence detectors (patterns 1101/1001, overlapping).
- Also emits per-word expected-detection tags so a bench can score a downstream detector.

Parameters:
- WIDTH, 4, data word width in bits; legal range 4..16.
- GAP, 0, number of idle cycles inserted after each word; legal range 0..15.
- IDLE_BIT, 1'b0, value driven on dout when no data bit is being sent.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled on handshake.
- load  input  1  word valid.
- ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit stream (detector din).
- dout_valid  output  1  dout carries a data (or parity) bit.
- last_bit  output  1  final bit of the current word is on dout.
- tag_1101  output  1  pulses with last_bit when the last four data bits sent are 1101.
- tag_1001  output  1  pulses with last_bit when the last four data bits sent are 1001.
- busy  output  1  FSM not in IDLE.

Behaviour:
- All outputs are registered. dout is taken from the shift-register MSB; no combinational path from load to dout.
- Reset (async assert, synchronous release at the clock edge):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - dout=IDLE_BIT; dout_valid=0, last_bit=0, tag_1101=0, tag_1001=0, busy=0, ready=1.
- Handshake:
  - A word is accepted on a rising edge where load && ready.
  - data_in is captured on that edge; changes on data_in afterwards have no effect.
  - load while ready=0 is ignored; the word is not queued.
- FSM states and transitions:
  - IDLE: ready=1, dout=IDLE_BIT, dout_valid=0.
    - On accept: go to SHIFT. data_in[WIDTH-1] appears on dout in the cycle after the accepting edge. Latency is 1 clock.
  - SHIFT: dout=current MSB, dout_valid=1. Shift left one bit per clock; bit counter counts WIDTH bits.
    - On the final data bit: last_bit=1, and the tags are evaluated on data_in[3:0] as captured.
    - tag_1101=1 if that value equals 4'b1101; tag_1001=1 if it equals 4'b1001. At most one tag is set.
  - SHIFT exit, GAP=0:
    - ready=1 during the final-bit cycle.
    - Accept in that cycle: reload, stay in SHIFT. The next word's MSB follows immediately with no bubble, so patterns can overlap across word boundaries as a detector sees them.
    - No accept: go to IDLE.
  - SHIFT exit, GAP>0: go to GAP; ready=0 during the final-bit cycle.
  - GAP: dout=IDLE_BIT, dout_valid=0 for exactly GAP cycles.
    - ready=1 in the last GAP cycle. Accept there goes to SHIFT; otherwise go to IDLE.
- Tags are per-word only. Patterns that straddle a word boundary are never tagged.
- busy=1 in SHIFT and GAP.
- Reset asserted mid-word aborts immediately. dout returns to IDLE_BIT asynchronously; the partial word is discarded.
- The shift register and counters use WIDTH bits and $clog2-sized counters; no wrap beyond the WIDTH count.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one even-parity bit is sent (XOR of all data bits), with dout_valid=1.
  - last_bit and the tags move to the parity cycle.
  - Word length on the line is WIDTH+1; back-to-back and GAP rules apply after the parity bit.
- Not defined: no parity bit; the word is exactly WIDTH bits.

Test Plan:
- Reset, then load=1, data_in=4'b1101, GAP=0 → dout sequence 1,1,0,1 in cycles 1–4 after the accept; dout_valid=1 for those 4 cycles; last_bit and tag_1101 high in cycle 4; then dout=0, ready=1.
- Back-to-back: 4'b1001 then 4'b1101 with load held → 8 contiguous bits 1,0,0,1,1,1,0,1; tag_1001 in cycle 4, tag_1101 in cycle 8; no idle cycle in between. A connected 1x01 detector flags both patterns.
- GAP=2, two words 4'b1010 and 4'b0001 → 4 bits, 2 cycles of dout=IDLE_BIT with dout_valid=0, then 4 bits. ready is low in the final-bit cycle and high only in the second gap cycle. No tags fire.
- load pulsed while busy mid-word → ignored; the current word completes unchanged; the next load after ready=1 is accepted.
- reset asserted between clock edges during the 2nd bit of 4'b1101 → dout=0, dout_valid=0, ready=1 immediately; after release, a fresh word 4'b1001 transmits correctly.
- With SEQ_TX_PARITY_EN: word 4'b1101 → 1,1,0,1,1 (parity=1); last_bit and tag_1101 on the 5th bit; word 4'b1001 → parity 0.
